// File: rtl/sipo_rx_pkg.sv
// Shared types and constants for the framed serial receiver.
package sipo_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    // Level of a drained line; a start bit is the opposite level.
    localparam logic LINE_IDLE = 1'b0;

endpackage

// File: rtl/sipo_frame_rx_if.sv
// Serial-in / parallel-out bundle between the receiver and its environment.
interface sipo_frame_rx_if #(
    parameter int unsigned N = 8
);
    logic         bit_en;
    logic         sin;
    logic [N-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         parity_err;
    logic         frame_err;
    logic         overrun;
    logic         clr_err;
    logic         busy;

    modport slave (
        input  bit_en, sin, dout_ready, clr_err,
        output dout, dout_valid, parity_err, frame_err, overrun, busy
    );

    modport master (
        output bit_en, sin, dout_ready, clr_err,
        input  dout, dout_valid, parity_err, frame_err, overrun, busy
    );
endinterface

// File: rtl/sipo_rx_hold.sv
// One-entry valid/ready holding register with sticky overrun detection.
module sipo_rx_hold #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         commit_c,
    input  logic [W-1:0] wdata,
    input  logic         ready,
    input  logic         clr_err,
    output logic [W-1:0] data_q,
    output logic         valid_q,
    output logic         overrun_q
);

    logic [W-1:0] data_d;
    logic         valid_d;
    logic         overrun_d;
    logic         pop_c;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        pop_c     = valid_q & ready;

        if (pop_c) begin
            valid_d = 1'b0;
        end
        if (clr_err) begin
            overrun_d = 1'b0;
        end
        // A commit may reuse the slot being drained this cycle; otherwise it is lost.
        if (commit_c) begin
            if (!valid_q || pop_c) begin
                data_d  = wdata;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: rtl/sipo_frame_rx.sv
// Framed serial receiver: start bit, N data bits MSB first, optional even parity, stop bit.
module sipo_frame_rx
    import sipo_rx_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned PARITY_EN = 1
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    sipo_frame_rx_if.slave  rx
);

    localparam int unsigned CNT_W  = $clog2(N);
    localparam int unsigned HOLD_W = N + 1;

    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       sreg_q, sreg_d;
    logic               perr_q, perr_d;
    logic               frame_err_q, frame_err_d;
    logic               busy_q, busy_d;
    logic               commit_c;
    logic [HOLD_W-1:0]  hold_data;
    logic               hold_valid;
    logic               hold_overrun;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sreg_d      = sreg_q;
        perr_d      = perr_q;
        frame_err_d = 1'b0;
        commit_c    = 1'b0;

        if (rx.bit_en) begin
            case (state_q)
                IDLE: begin
                    if (rx.sin != LINE_IDLE) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        perr_d  = 1'b0;
                    end
                end
                DATA: begin
                    sreg_d = {sreg_q[N-2:0], rx.sin};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N - 1)) begin
                        cnt_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    perr_d  = (^sreg_q) ^ rx.sin;
                    state_d = STOP;
                end
                STOP: begin
                    // A high stop bit rejects the frame and is not taken as a new start.
                    if (rx.sin == LINE_IDLE) begin
                        commit_c = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sreg_q      <= '0;
            perr_q      <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sreg_q      <= sreg_d;
            perr_q      <= perr_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    sipo_rx_hold #(
        .W (HOLD_W)
    ) u_hold (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .commit_c  (commit_c),
        .wdata     ({perr_q, sreg_q}),
        .ready     (rx.dout_ready),
        .clr_err   (rx.clr_err),
        .data_q    (hold_data),
        .valid_q   (hold_valid),
        .overrun_q (hold_overrun)
    );

    assign rx.dout       = hold_data[N-1:0];
    assign rx.parity_err = hold_data[N];
    assign rx.dout_valid = hold_valid;
    assign rx.overrun    = hold_overrun;
    assign rx.frame_err  = frame_err_q;
    assign rx.busy       = busy_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed and randomized frames checked against a frame-level reference model.
module tb_sipo_frame_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sipo_frame_rx_if #(.N(8)) rx_if ();

    sipo_frame_rx #(.N(8), .PARITY_EN(1)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .rx      (rx_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic even_pbit(input logic [7:0] w);
        return ^w;
    endfunction

    // Drives one whole frame; strobes bit_en once every `stride` cycles and
    // scrambles sin on the non-strobe cycles. Ends right after the stop-bit edge.
    task automatic send_frame(input logic [7:0] w, input logic pbit, input logic stop,
                              input int stride);
        logic [10:0] bits;
        bits = {1'b1, w, pbit, stop};
        for (int k = 10; k >= 0; k--) begin
            rx_if.sin    = bits[k];
            rx_if.bit_en = 1'b1;
            tick();
            rx_if.bit_en = 1'b0;
            if (k != 0) begin
                check("busy_in_frame", 32'(rx_if.busy), 32'd1);
                for (int s = 1; s < stride; s++) begin
                    rx_if.sin = 1'($urandom);
                    tick();
                    check("busy_gap", 32'(rx_if.busy), 32'd1);
                end
            end
        end
        rx_if.sin = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [7:0] w, input logic perr);
        check({tag, "_valid"}, 32'(rx_if.dout_valid), 32'd1);
        check({tag, "_dout"}, 32'(rx_if.dout), 32'(w));
        check({tag, "_perr"}, 32'(rx_if.parity_err), 32'(perr));
        check({tag, "_busy"}, 32'(rx_if.busy), 32'd0);
    endtask

    initial begin
        logic [7:0] w;
        logic       pb;
        logic       stop;
        int         stride;

        rx_if.bit_en     = 1'b0;
        rx_if.sin        = 1'b0;
        rx_if.dout_ready = 1'b1;
        rx_if.clr_err    = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(rx_if.dout_valid), 32'd0);
        check("rst_dout", 32'(rx_if.dout), 32'd0);
        check("rst_busy", 32'(rx_if.busy), 32'd0);
        check("rst_overrun", 32'(rx_if.overrun), 32'd0);
        rst = 1'b0;
        tick();

        // Basic word, valid for exactly one cycle with ready high.
        send_frame(8'hA5, 1'b0, 1'b0, 1);
        expect_word("a5", 8'hA5, 1'b0);
        tick();
        check("a5_one_cycle", 32'(rx_if.dout_valid), 32'd0);

        // Wrong parity bit.
        send_frame(8'h01, 1'b0, 1'b0, 1);
        expect_word("p01", 8'h01, 1'b1);
        check("p01_overrun", 32'(rx_if.overrun), 32'd0);
        tick();

        // Bad stop bit, then a good frame.
        send_frame(8'h3C, 1'b0, 1'b1, 1);
        check("fe_pulse", 32'(rx_if.frame_err), 32'd1);
        check("fe_valid", 32'(rx_if.dout_valid), 32'd0);
        check("fe_busy", 32'(rx_if.busy), 32'd0);
        tick();
        check("fe_once", 32'(rx_if.frame_err), 32'd0);
        check("fe_idle", 32'(rx_if.busy), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1);
        expect_word("5a", 8'h5A, 1'b0);
        tick();

        // Overrun while the consumer stalls.
        rx_if.dout_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1);
        expect_word("h11", 8'h11, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1);
        check("ovr_dout", 32'(rx_if.dout), 32'h11);
        check("ovr_valid", 32'(rx_if.dout_valid), 32'd1);
        check("ovr_flag", 32'(rx_if.overrun), 32'd1);
        tick();
        check("ovr_sticky", 32'(rx_if.overrun), 32'd1);
        rx_if.dout_ready = 1'b1;
        rx_if.clr_err    = 1'b1;
        tick();
        rx_if.clr_err = 1'b0;
        check("clr_valid", 32'(rx_if.dout_valid), 32'd0);
        check("clr_overrun", 32'(rx_if.overrun), 32'd0);

        // Sparse strobe with garbage on sin between strobes, including in IDLE.
        for (int s = 0; s < 4; s++) begin
            rx_if.sin = 1'($urandom);
            tick();
            check("idle_ignores_sin", 32'(rx_if.busy), 32'd0);
        end
        send_frame(8'hC3, 1'b0, 1'b0, 4);
        expect_word("c3", 8'hC3, 1'b0);
        tick();

        // Randomized frames against the frame-level model.
        for (int i = 0; i < 40; i++) begin
            w      = 8'($urandom);
            pb     = even_pbit(w) ^ ($urandom_range(0, 3) == 0);
            stop   = ($urandom_range(0, 4) == 0);
            stride = $urandom_range(1, 3);
            send_frame(w, pb, stop, stride);
            if (stop) begin
                check("rnd_fe", 32'(rx_if.frame_err), 32'd1);
                check("rnd_fe_valid", 32'(rx_if.dout_valid), 32'd0);
            end else begin
                expect_word("rnd", w, pb ^ even_pbit(w));
                check("rnd_fe_low", 32'(rx_if.frame_err), 32'd0);
            end
            check("rnd_overrun", 32'(rx_if.overrun), 32'd0);
            tick();
        end

        // Asynchronous reset mid-frame: start plus four data bits of 0xFF.
        send_frame(8'h3C, 1'b0, 1'b0, 1);
        rx_if.dout_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            rx_if.sin    = 1'b1;
            rx_if.bit_en = 1'b1;
            tick();
        end
        check("pre_rst_busy", 32'(rx_if.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(rx_if.busy), 32'd0);
        check("arst_valid", 32'(rx_if.dout_valid), 32'd0);
        check("arst_dout", 32'(rx_if.dout), 32'd0);
        check("arst_perr", 32'(rx_if.parity_err), 32'd0);
        rx_if.bit_en     = 1'b0;
        rx_if.sin        = 1'b0;
        rx_if.dout_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        send_frame(8'h81, 1'b0, 1'b0, 1);
        expect_word("h81", 8'h81, 1'b0);
        tick();
        check("h81_drained", 32'(rx_if.dout_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sipo_frame_rx.md
Name: sipo_frame_rx

Overview:
- Downstream companion of the team's parallel-in/serial-out shifter: receives a framed serial bit stream, MSB first, and rebuilds N-bit parallel words.
- Frame format: start bit (1), N data bits MSB first, optional even-parity bit, stop bit (0). The line idles at 0, which is the shifter's drained-output level.
- Delivers each word through a one-entry valid/ready holding register, and flags parity, framing and overrun errors.

Parameters:
- N, 8, data word width in bits; legal range 2..32.
- PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.

Ports:
- sys_clk  in  1  system clock; all state changes on the rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- bit_en  in  1  bit-sample strobe; the FSM advances only on cycles where bit_en=1.
- sin  in  1  serial data in; sampled when bit_en=1.
- dout  out  N  received word.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  consumer accepts dout when dout_valid&dout_ready.
- parity_err  out  1  parity status of the word in dout; valid while dout_valid=1.
- frame_err  out  1  one-cycle pulse when a frame is rejected because its stop bit was 1.
- overrun  out  1  sticky flag: a good frame was dropped because the holding register was full.
- clr_err  in  1  synchronous clear of overrun.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Interface: one clock, sys_clk; reset is asynchronous and active-high, sys_rst.
- Reset values: every output 0, FSM in IDLE, bit counter 0, shift register 0.
- Reset asserted mid-frame aborts the frame immediately; the partial word is discarded.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions require bit_en=1; with bit_en=0 all state holds.
- IDLE: sin=1 -> DATA with cnt=0; sin=0 -> stay in IDLE.
- DATA: shift sreg <= {sreg[N-2:0], sin} and cnt++. On the Nth bit (cnt==N-1): go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: capture perr = (^sreg) ^ sin; even parity, so 1 = error. Then go to STOP.
- STOP, sin=0 (good frame): commit sreg to the holding register (rules below), then go to IDLE.
- STOP, sin=1 (framing error): pulse frame_err in the next cycle, drop the word, go to IDLE. The 1 is not reinterpreted as a start bit.
- Commit rules for a good frame:
  - Holding register empty, or being drained in the same cycle (dout_valid&dout_ready): dout<=sreg, parity_err<=perr (0 if PARITY_EN=0), dout_valid<=1.
  - Otherwise: word dropped, overrun<=1, and dout/parity_err stay unchanged.
- Latency: dout_valid rises in the cycle after the bit_en cycle that sampled the stop bit.
- Holding register: dout and parity_err are stable while dout_valid=1 and dout_ready=0. A pop with no new commit clears dout_valid next cycle; a pop and a commit in the same cycle keep dout_valid=1 with the new word.
- dout_ready while dout_valid=0 has no effect.
- overrun is cleared only by clr_err or reset. If clr_err and a new overrun event fall in the same cycle, set wins.
- cnt width is $clog2(N); no wrap beyond N-1 is ever reached.

Decomposition:
- Shared package sipo_rx_pkg: state enum (IDLE, DATA, PARITY, STOP) and a localparam for the idle line level (0).
- One sub-module, sipo_rx_hold: the one-entry holding register with the valid/ready and overrun logic, parameterised on N+1 bits (data plus parity flag).
- The FSM and shift register live in the top level.

Test Plan:
- N=8, PARITY_EN=1, bit_en=1 every cycle, dout_ready=1; send 1,10100101,0,0 -> dout=8'hA5, parity_err=0, dout_valid high for one cycle, 1 cycle after the stop bit.
- Send 0x01 with parity bit 0 (wrong) -> dout=8'h01, parity_err=1, overrun=0.
- Send 0x3C with stop bit 1 -> frame_err pulses once, dout_valid stays 0, FSM back in IDLE; a following good 0x5A is received intact.
- dout_ready=0; send 0x11 then 0x22 -> dout=8'h11 held, overrun=1. Then raise dout_ready and pulse clr_err -> dout_valid drops, overrun=0.
- bit_en=1 only every 4th cycle; send 0xC3 -> same result as every-cycle strobing, with busy=1 throughout the frame; sin toggling while bit_en=0 is ignored.
- Assert sys_rst asynchronously after the 4th data bit of 0xFF -> all outputs 0 immediately; after release a full 0x81 frame is received correctly.
